// File: rtl/mux_serializer_ctrl.sv
// Parallel-to-serial controller for the 4:1 bit mux: latches a word, walks the mux
// select through all four positions with a programmable dwell, and registers q as a strobed stream.
module mux_serializer_ctrl #(
    parameter int unsigned DWELL = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic [3:0] in_data,
    input  logic       msb_first,
    output logic [1:0] select,
    output logic [3:0] d,
    input  logic       q,
    output logic       ser_out,
    output logic       ser_valid,
    output logic       frame_start,
    output logic       done,
    output logic       busy
);

    localparam logic [0:0] StIdle    = 1'b0;
    localparam logic [0:0] StShift   = 1'b1;
    localparam logic [7:0] DwellLast = 8'(DWELL - 1);

    logic [0:0] state_q;
    logic [7:0] dwell_cnt_q;
    logic [1:0] bit_idx_q;
    logic       order_q;

    logic bit_end;
    logic last_bit;
    logic accept;

    assign bit_end  = (state_q == StShift) && (dwell_cnt_q == DwellLast);
    assign last_bit = bit_end && (bit_idx_q == 2'd3);
    // A new word may be taken on the same edge that samples the final bit.
    assign in_ready = !rst && ((state_q == StIdle) || last_bit);
    assign accept   = in_valid && in_ready;
    assign busy     = (state_q == StShift);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= StIdle;
            dwell_cnt_q <= 8'd0;
            bit_idx_q   <= 2'd0;
            order_q     <= 1'b0;
            select      <= 2'd0;
            d           <= 4'd0;
            ser_out     <= 1'b0;
            ser_valid   <= 1'b0;
            frame_start <= 1'b0;
            done        <= 1'b0;
        end else begin
            ser_valid   <= 1'b0;
            frame_start <= 1'b0;
            done        <= 1'b0;

            if (state_q == StShift) begin
                dwell_cnt_q <= dwell_cnt_q + 8'd1;
                if (bit_end) begin
                    ser_out     <= q;
                    ser_valid   <= 1'b1;
                    frame_start <= (bit_idx_q == 2'd0);
                    done        <= (bit_idx_q == 2'd3);
                    dwell_cnt_q <= 8'd0;
                    bit_idx_q   <= bit_idx_q + 2'd1;
                    // The final position is held into IDLE rather than wrapping.
                    if (last_bit) begin
                        state_q <= StIdle;
                    end else begin
                        select <= order_q ? (select - 2'd1) : (select + 2'd1);
                    end
                end
            end

            // Accept overrides the bit-end bookkeeping when frames run back to back.
            if (accept) begin
                d           <= in_data;
                order_q     <= msb_first;
                select      <= msb_first ? 2'd3 : 2'd0;
                dwell_cnt_q <= 8'd0;
                bit_idx_q   <= 2'd0;
                state_q     <= StShift;
            end
        end
    end

endmodule

// File: tb/tb_mux_serializer_ctrl.sv
// Bench for mux_serializer_ctrl: two instances (DWELL 1 and 3) driven by directed and random
// words; a scoreboard of expected strobes (bit, timing, select, framing) is checked by a monitor.
module tb_mux_serializer_ctrl;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst         [2];
    logic       in_valid    [2];
    logic       in_ready    [2];
    logic [3:0] in_data     [2];
    logic       msb_first   [2];
    logic [1:0] select      [2];
    logic [3:0] d           [2];
    logic       q           [2];
    logic       ser_out     [2];
    logic       ser_valid   [2];
    logic       frame_start [2];
    logic       done        [2];
    logic       busy        [2];

    // Behavioural 4:1 mux standing in for the real one.
    assign q[0] = d[0][select[0]];
    assign q[1] = d[1][select[1]];

    mux_serializer_ctrl #(.DWELL(1)) u_dut0 (
        .clk(clk), .rst(rst[0]), .in_valid(in_valid[0]), .in_ready(in_ready[0]),
        .in_data(in_data[0]), .msb_first(msb_first[0]), .select(select[0]), .d(d[0]),
        .q(q[0]), .ser_out(ser_out[0]), .ser_valid(ser_valid[0]),
        .frame_start(frame_start[0]), .done(done[0]), .busy(busy[0])
    );

    mux_serializer_ctrl #(.DWELL(3)) u_dut1 (
        .clk(clk), .rst(rst[1]), .in_valid(in_valid[1]), .in_ready(in_ready[1]),
        .in_data(in_data[1]), .msb_first(msb_first[1]), .select(select[1]), .d(d[1]),
        .q(q[1]), .ser_out(ser_out[1]), .ser_valid(ser_valid[1]),
        .frame_start(frame_start[1]), .done(done[1]), .busy(busy[1])
    );

    typedef struct {
        int       inst;
        int       t;
        bit       ser;
        bit       fs;
        bit       dn;
        logic [1:0] sel;
    } exp_t;

    exp_t       sb[$];
    int         checks = 0;
    int         errors = 0;
    int         cyc = 0;
    logic [1:0] prev_sel [2];

    always @(posedge clk) cyc <= cyc + 1;

    function automatic int dw(input int i);
        return (i == 0) ? 1 : 3;
    endfunction

    function automatic int find_exp(input int i);
        foreach (sb[k]) if (sb[k].inst == i) return k;
        return -1;
    endfunction

    function automatic int pending(input int i);
        int n = 0;
        foreach (sb[k]) if (sb[k].inst == i) n++;
        return n;
    endfunction

    task automatic chk(input string name, input int i, input logic [31:0] act,
                       input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s dut%0d t=%0t actual=%0h required=%0h", name, i, $time, act, req);
        end
    endtask

    // Strobe k of a word accepted at edge cyc lands in the cycle after edge cyc+(k+1)*DWELL.
    task automatic push_exp(input int i, input logic [3:0] w, input bit m);
        exp_t e;
        for (int k = 0; k < 4; k++) begin
            e.inst = i;
            e.t    = cyc + (k + 1) * dw(i);
            e.ser  = m ? w[3 - k] : w[k];
            e.fs   = (k == 0);
            e.dn   = (k == 3);
            e.sel  = m ? 2'(3 - k) : 2'(k);
            sb.push_back(e);
        end
    endtask

    task automatic mon(input int i);
        int   k;
        exp_t e;
        k = find_exp(i);
        if (ser_valid[i] === 1'b1) begin
            if (k < 0) begin
                chk("unexpected_strobe", i, 32'(ser_valid[i]), 32'(0));
            end else begin
                e = sb[k];
                sb.delete(k);
                chk("strobe_cycle", i, cyc, e.t);
                chk("ser_out", i, 32'(ser_out[i]), 32'(e.ser));
                chk("frame_start", i, 32'(frame_start[i]), 32'(e.fs));
                chk("done", i, 32'(done[i]), 32'(e.dn));
                chk("select_at_sample", i, 32'(prev_sel[i]), 32'(e.sel));
            end
        end else begin
            chk("frame_start_idle", i, 32'(frame_start[i]), 32'(0));
            chk("done_idle", i, 32'(done[i]), 32'(0));
            if (k >= 0 && sb[k].t <= cyc) begin
                chk("strobe_missing", i, 32'(ser_valid[i]), 32'(1));
                sb.delete(k);
            end
        end
        prev_sel[i] = select[i];
    endtask

    always @(negedge clk) begin
        if (cyc > 0) begin
            mon(0);
            mon(1);
        end
    end

    task automatic send(input int i, input logic [3:0] w, input bit m, output int waited);
        @(posedge clk);
        #1;
        in_valid[i]  = 1'b1;
        in_data[i]   = w;
        msb_first[i] = m;
        waited = 0;
        while (waited < 1000) begin
            @(negedge clk);
            waited++;
            if (in_ready[i] === 1'b1) break;
        end
        chk("accept", i, 32'(in_ready[i]), 32'(1));
        if (in_ready[i] !== 1'b1) begin
            in_valid[i] = 1'b0;
            return;
        end
        @(posedge clk);
        #1;
        push_exp(i, w, m);
        // Scramble inputs after accept: only the accepted values may matter.
        in_valid[i]  = 1'b0;
        in_data[i]   = 4'($urandom);
        msb_first[i] = 1'($urandom);
    endtask

    task automatic wait_drain(input int i);
        int n = 0;
        while (pending(i) > 0 && n < 500) begin
            @(negedge clk);
            #1;
            n++;
        end
        chk("drain", i, 32'(pending(i)), 32'(0));
    endtask

    task automatic flush_future(input int i, input int now);
        for (int k = sb.size() - 1; k >= 0; k--)
            if (sb[k].inst == i && sb[k].t > now) sb.delete(k);
    endtask

    task automatic chk_reset_state(input int i);
        chk("rst_in_ready", i, 32'(in_ready[i]), 32'(0));
        chk("rst_select", i, 32'(select[i]), 32'(0));
        chk("rst_d", i, 32'(d[i]), 32'(0));
        chk("rst_ser_out", i, 32'(ser_out[i]), 32'(0));
        chk("rst_ser_valid", i, 32'(ser_valid[i]), 32'(0));
        chk("rst_frame_start", i, 32'(frame_start[i]), 32'(0));
        chk("rst_done", i, 32'(done[i]), 32'(0));
        chk("rst_busy", i, 32'(busy[i]), 32'(0));
    endtask

    task automatic abort_test(input int i);
        int         waited;
        int         n;
        logic [3:0] w2;
        bit         m2;
        send(i, 4'($urandom), 1'($urandom), waited);
        n = 0;
        while (pending(i) > 2 && n < 200) begin
            @(negedge clk);
            #1;
            n++;
        end
        chk("abort_two_strobes", i, 32'(pending(i)), 32'(2));
        @(posedge clk);
        #1;
        // Offer a word during reset: reset must win.
        w2           = 4'($urandom);
        m2           = 1'($urandom);
        rst[i]       = 1'b1;
        in_valid[i]  = 1'b1;
        in_data[i]   = w2;
        msb_first[i] = m2;
        flush_future(i, cyc);
        @(posedge clk);
        #1;
        rst[i] = 1'b0;
        @(negedge clk);
        chk("abort_select", i, 32'(select[i]), 32'(0));
        chk("abort_d", i, 32'(d[i]), 32'(0));
        chk("abort_busy", i, 32'(busy[i]), 32'(0));
        chk("abort_ready", i, 32'(in_ready[i]), 32'(1));
        @(posedge clk);
        #1;
        push_exp(i, w2, m2);
        in_valid[i] = 1'b0;
        @(negedge clk);
        chk("abort_reaccept_busy", i, 32'(busy[i]), 32'(1));
        wait_drain(i);
    endtask

    initial begin
        int waited;
        int gap;
        for (int i = 0; i < 2; i++) begin
            rst[i]       = 1'b1;
            in_valid[i]  = 1'b1;
            in_data[i]   = 4'($urandom);
            msb_first[i] = 1'b0;
        end
        repeat (3) begin
            @(negedge clk);
            for (int i = 0; i < 2; i++) chk_reset_state(i);
        end
        @(posedge clk);
        #1;
        for (int i = 0; i < 2; i++) begin
            rst[i]      = 1'b0;
            in_valid[i] = 1'b0;
        end
        @(negedge clk);
        for (int i = 0; i < 2; i++) begin
            chk("post_rst_busy", i, 32'(busy[i]), 32'(0));
            chk("post_rst_ready", i, 32'(in_ready[i]), 32'(1));
        end

        // DWELL = 1: LSB-first, MSB-first, back-to-back.
        send(0, 4'b1011, 1'b0, waited);
        wait_drain(0);
        chk("busy_after_done", 0, 32'(busy[0]), 32'(0));
        send(0, 4'b1011, 1'b1, waited);
        wait_drain(0);
        send(0, 4'hA, 1'b0, waited);
        send(0, 4'h5, 1'b0, waited);
        chk("b2b_ready_cycle", 0, 32'(waited), 32'(4 * dw(0) - 1));
        wait_drain(0);

        // DWELL = 3: single frame, then back-to-back.
        send(1, 4'b0110, 1'b0, waited);
        send(1, 4'($urandom), 1'($urandom), waited);
        chk("b2b_ready_cycle", 1, 32'(waited), 32'(4 * dw(1) - 1));
        wait_drain(1);

        abort_test(0);
        abort_test(1);

        for (int i = 0; i < 2; i++) begin
            repeat (12) begin
                gap = int'($urandom_range(0, 2));
                repeat (gap) @(posedge clk);
                send(i, 4'($urandom), 1'($urandom), waited);
            end
            wait_drain(i);
        end

        repeat (5) @(posedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
